// File: rtl/cache_refill_ctrl_pkg.sv
// Shared cache geometry, refill FSM encoding and block address helper.
// Also used by the cache front end and hit path.
package cache_pkg;

  localparam int ADDR_W    = 15;
  localparam int INDEX_W   = 8;
  localparam int TAG_W     = ADDR_W - INDEX_W - 2;
  localparam int MEM_DEPTH = 32000;
  localparam int LINE_W    = 128;
  localparam int WORD_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FILL = 2'd2,
    ERR  = 2'd3
  } refill_state_t;

  // A block is four words, so its base simply clears the two offset bits.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Bundle of the miss request, memory block-read, cache write and response signals.
// The master side is the front end/memory environment; the slave side is the refill controller.
interface cache_refill_if;
  import cache_pkg::*;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only while the controller is idle, and there is no queueing.
  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr;
  logic [ADDR_W-1:0]   mem_addr;
  logic [WORD_W-1:0]   mem_w3;
  logic [WORD_W-1:0]   mem_w2;
  logic [WORD_W-1:0]   mem_w1;
  logic [WORD_W-1:0]   mem_w0;
  logic                cache_we;
  logic [INDEX_W-1:0]  cache_index;
  logic [TAG_W-1:0]    cache_tag;
  logic [LINE_W-1:0]   cache_line;
  logic                resp_valid;
  logic [WORD_W-1:0]   resp_data;
  logic                resp_err;
  logic [15:0]         refill_cnt;

  modport master (
    output req_valid, req_addr, mem_w3, mem_w2, mem_w1, mem_w0,
    input  req_ready, mem_addr, cache_we, cache_index, cache_tag, cache_line,
           resp_valid, resp_data, resp_err, refill_cnt
  );

  modport slave (
    input  req_valid, req_addr, mem_w3, mem_w2, mem_w1, mem_w0,
    output req_ready, mem_addr, cache_we, cache_index, cache_tag, cache_line,
           resp_valid, resp_data, resp_err, refill_cnt
  );

endinterface

// File: rtl/cache_refill_ctrl_line_word_sel.sv
// Combinational 4:1 word select from a cache line by block offset.
module line_word_sel
  import cache_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [1:0]        offset,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    word = '0;
    case (offset)
      2'd0: word = line[31:0];
      2'd1: word = line[63:32];
      2'd2: word = line[95:64];
      2'd3: word = line[127:96];
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-side refill initiator: fetches a 4-word block after a fixed memory latency,
// writes it into the cache arrays and returns the requested word with a one-cycle pulse.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int MEM_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  cache_refill_if.slave bus,
  output refill_state_t dbg_state
);

  refill_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] line_q;
  logic [3:0]        wcnt_q;
  logic [15:0]       cnt_q;
  logic              out_of_range;
  logic [WORD_W-1:0] sel_word;

  // The whole block must fit: its last word is base + 3.
  assign out_of_range = (32'(block_base(bus.req_addr)) + 32'd3) >= 32'(MEM_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.req_valid) state_d = out_of_range ? ERR : WAIT;
      WAIT: if (wcnt_q == 4'd0) state_d = FILL;
      FILL: state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      line_q <= '0;
      wcnt_q <= '0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          addr_q <= bus.req_addr;
          if (!out_of_range) wcnt_q <= 4'(MEM_LAT - 1);
        end
        WAIT: begin
          // Memory words are only trusted on the final wait edge.
          if (wcnt_q == 4'd0) line_q <= {bus.mem_w3, bus.mem_w2, bus.mem_w1, bus.mem_w0};
          else                wcnt_q <= wcnt_q - 4'd1;
        end
        FILL: if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        default: ;
      endcase
    end
  end

  line_word_sel u_word_sel (
    .line   (line_q),
    .offset (addr_q[1:0]),
    .word   (sel_word)
  );

  always_comb begin
    bus.req_ready   = (state_q == IDLE);
    bus.mem_addr    = block_base(addr_q);
    bus.cache_index = addr_q[INDEX_W+1:2];
    bus.cache_tag   = addr_q[ADDR_W-1:INDEX_W+2];
    bus.cache_line  = line_q;
    bus.cache_we    = (state_q == FILL);
    bus.resp_valid  = (state_q == FILL) || (state_q == ERR);
    bus.resp_err    = (state_q == ERR);
    bus.resp_data   = (state_q == FILL) ? sel_word : '0;
    bus.refill_cnt  = cnt_q;
    dbg_state       = state_q;
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a behavioural main memory.
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  localparam int LAT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_refill_if bus();
  refill_state_t  dbg_state;

  cache_refill_ctrl #(.MEM_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- memory model ----------------
  logic [31:0] mem_xor = 32'h0;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a >= 15'h104 && a <= 15'h107) return 32'hA0 + 32'(a - 15'h104);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  always_comb begin
    bus.mem_w0 = mem_word(bus.mem_addr)          ^ mem_xor;
    bus.mem_w1 = mem_word(bus.mem_addr + 15'd1) ^ mem_xor;
    bus.mem_w2 = mem_word(bus.mem_addr + 15'd2) ^ mem_xor;
    bus.mem_w3 = mem_word(bus.mem_addr + 15'd3) ^ mem_xor;
  end

  // ---------------- pulse monitor ----------------
  int cyc_n = 0, we_cnt = 0, resp_cnt = 0, last_resp = 0, prev_resp = 0;
  always @(negedge clk) begin
    cyc_n++;
    if (bus.cache_we) we_cnt++;
    if (bus.resp_valid) begin
      resp_cnt++;
      prev_resp = last_resp;
      last_resp = cyc_n;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request and follows it to its response; optionally pokes a
  // rejected request and corrupts memory during the early wait cycles.
  task automatic do_req(input logic [ADDR_W-1:0] addr, input bit exp_err,
                        input logic [31:0] exp_data, input bit inject);
    int cyc;
    logic [ADDR_W-1:0] b;
    b = {addr[ADDR_W-1:2], 2'b00};
    @(negedge clk);
    chk("ready_idle", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    cyc = 1;
    chk("ready_busy", bus.req_ready, 1'b0);
    while (!bus.resp_valid && cyc < 20) begin
      if (inject && cyc == 2) begin
        bus.req_valid = 1'b1;
        bus.req_addr  = 15'h200;
        mem_xor       = 32'hFFFF_FFFF;
      end else begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        mem_xor       = 32'h0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.req_valid = 1'b0;
    mem_xor       = 32'h0;
    chk("resp_latency", cyc, exp_err ? 1 : LAT + 1);
    chk("resp_err", bus.resp_err, exp_err);
    chk("cache_we", bus.cache_we, !exp_err);
    chk("resp_data", bus.resp_data, exp_err ? 32'h0 : exp_data);
    chk("mem_addr", bus.mem_addr, b);
    chk("cache_index", bus.cache_index, addr[INDEX_W+1:2]);
    chk("cache_tag", bus.cache_tag, addr[ADDR_W-1:INDEX_W+2]);
    if (!exp_err)
      chk("cache_line", bus.cache_line,
          {mem_word(b + 15'd3), mem_word(b + 15'd2), mem_word(b + 15'd1), mem_word(b)});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_refill_cnt", bus.refill_cnt, 16'h0);
    chk("rst_cache_we", bus.cache_we, 1'b0);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_err", bus.resp_err, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 15'h0);
    chk("rst_cache_line", bus.cache_line, 128'h0);
    chk("rst_resp_data", bus.resp_data, 32'h0);
    chk("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;

    // Basic refill
    do_req(15'h0106, 1'b0, 32'hA2, 1'b0);
    chk("basic_mem_addr", bus.mem_addr, 15'h104);
    chk("basic_index", bus.cache_index, 8'h41);
    chk("basic_line", bus.cache_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    @(negedge clk); #1;
    chk("basic_pulse_low", bus.resp_valid, 1'b0);
    chk("basic_we_low", bus.cache_we, 1'b0);
    chk("basic_cnt", bus.refill_cnt, 16'd1);
    chk("basic_we_count", we_cnt, 1);
    chk("basic_resp_count", resp_cnt, 1);

    // Busy rejection plus early memory corruption that must be ignored
    do_req(15'h0106, 1'b0, 32'hA2, 1'b1);
    repeat (8) @(negedge clk); #1;
    chk("busy_resp_count", resp_cnt, 2);
    chk("busy_we_count", we_cnt, 2);
    chk("busy_cnt", bus.refill_cnt, 16'd2);
    chk("busy_state", dbg_state, IDLE);

    // Highest in-range block: 31996..31999 fits a 32000-word memory
    do_req(15'd31998, 1'b0, 32'hC0DE_7CFE, 1'b0);
    chk("edge_tag", bus.cache_tag, 5'h1F);
    chk("edge_index", bus.cache_index, 8'h3F);
    @(negedge clk); #1;
    chk("edge_cnt", bus.refill_cnt, 16'd3);

    // Out of range blocks
    do_req(15'd32000, 1'b1, 32'h0, 1'b0);
    @(negedge clk); #1;
    chk("err_pulse_low", bus.resp_err, 1'b0);
    chk("err_cnt", bus.refill_cnt, 16'd3);
    chk("err_we_count", we_cnt, 3);
    chk("err_resp_count", resp_cnt, 4);
    do_req(15'h7FFF, 1'b1, 32'h0, 1'b0);
    @(negedge clk); #1;
    chk("err2_resp_count", resp_cnt, 5);
    chk("err2_cnt", bus.refill_cnt, 16'd3);

    // Reset during the second wait cycle
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 15'h020;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", bus.req_ready, 1'b1);
    chk("abort_resp", bus.resp_valid, 1'b0);
    chk("abort_cnt", bus.refill_cnt, 16'd0);
    chk("abort_state", dbg_state, IDLE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk); #1;
    chk("abort_we_count", we_cnt, 3);
    chk("abort_resp_count", resp_cnt, 5);
    do_req(15'h008, 1'b0, 32'hC0DE_0008, 1'b0);
    @(negedge clk); #1;
    chk("post_abort_cnt", bus.refill_cnt, 16'd1);

    // Saturation and back-to-back throughput
    @(negedge clk);
    force dut.cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.cnt_q;
    #1;
    chk("sat_preload", bus.refill_cnt, 16'hFFFE);
    do_req(15'h010, 1'b0, 32'hC0DE_0010, 1'b0);
    do_req(15'h01F, 1'b0, 32'hC0DE_001F, 1'b0);
    @(negedge clk); #1;
    chk("sat_cnt", bus.refill_cnt, 16'hFFFF);
    chk("b2b_gap", last_resp - prev_resp, LAT + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
